// File: rtl/cmp_defs.sv
// Shared definitions for the iterative comparator: state encoding and
// constant-width helpers used to size the slice counter.
package cmp_defs;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COMPARE = ST_COMPARE,
    DONE    = ST_DONE
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single-slice configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/comparator_slice.sv
// Combinational magnitude compare of one slice; sign_msb_i inverts the top bit
// of both operands so a two's-complement slice orders correctly as unsigned.
module comparator_slice #(
  parameter int SLICE_WIDTH = 8
) (
  input  logic [SLICE_WIDTH-1:0] a_i,
  input  logic [SLICE_WIDTH-1:0] b_i,
  input  logic                   sign_msb_i,
  output logic                   gt_o,
  output logic                   eq_o,
  output logic                   lt_o
);

  logic [SLICE_WIDTH-1:0] msb_mask;
  logic [SLICE_WIDTH-1:0] a_x;
  logic [SLICE_WIDTH-1:0] b_x;

  assign msb_mask = SLICE_WIDTH'(sign_msb_i) << (SLICE_WIDTH - 1);
  assign a_x      = a_i ^ msb_mask;
  assign b_x      = b_i ^ msb_mask;

  assign gt_o = (a_x > b_x);
  assign eq_o = (a_x == b_x);
  assign lt_o = (a_x < b_x);

endmodule

// File: rtl/comparator_iterative.sv
// Multi-cycle magnitude comparator: one slice per clock, MSB slice first,
// early exit on the first unequal slice; result flags tristated by Enable_In.
module comparator_iterative
  import cmp_defs::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_n_In,
  input  logic                  Enable_In,
  input  logic                  Start_In,
  input  logic                  Signed_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Busy_Out,
  output logic                  Valid_Out,
  output logic                  A_gt_B_Out,
  output logic                  A_eq_B_Out,
  output logic                  A_lt_B_Out
);

  localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int CNT_W      = cnt_width(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    signed_q, signed_d;
  logic                    gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [SLICE_WIDTH-1:0]  a_slice, b_slice;
  logic                    s_gt, s_eq, s_lt;

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_slice = a_q[DATA_WIDTH-1-i*SLICE_WIDTH -: SLICE_WIDTH];
        b_slice = b_q[DATA_WIDTH-1-i*SLICE_WIDTH -: SLICE_WIDTH];
      end
    end
  end

  // Only the most significant slice carries the sign bit.
  comparator_slice #(.SLICE_WIDTH(SLICE_WIDTH)) u_slice (
    .a_i        (a_slice),
    .b_i        (b_slice),
    .sign_msb_i (signed_q && (cnt_q == '0)),
    .gt_o       (s_gt),
    .eq_o       (s_eq),
    .lt_o       (s_lt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start_In) begin
          a_d      = Data_A_In;
          b_d      = Data_B_In;
          signed_d = Signed_In;
          cnt_d    = '0;
          state_d  = COMPARE;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (!s_eq) begin
          gt_d    = s_gt;
          eq_d    = 1'b0;
          lt_d    = s_lt;
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign Busy_Out   = (state_q == COMPARE);
  assign Valid_Out  = (state_q == DONE);
  assign A_gt_B_Out = Enable_In ? gt_q : 1'bz;
  assign A_eq_B_Out = Enable_In ? eq_q : 1'bz;
  assign A_lt_B_Out = Enable_In ? lt_q : 1'bz;

endmodule

// File: tb/tb_comparator_iterative.sv
// Directed bench for comparator_iterative (32-bit operands, 8-bit slices):
// vector table plus hand-written sequences for ignore/reset/enable corners.
module tb_comparator_iterative;

  logic        Clk_In = 1'b0;
  logic        Reset_n_In;
  logic        Enable_In;
  logic        Start_In;
  logic        Signed_In;
  logic [31:0] Data_A_In;
  logic [31:0] Data_B_In;
  wire         Busy_Out;
  wire         Valid_Out;
  wire         A_gt_B_Out;
  wire         A_eq_B_Out;
  wire         A_lt_B_Out;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        gt;
    logic        eq;
    logic        lt;
    int          k;
    string       name;
  } vec_t;

  vec_t vecs[12];

  comparator_iterative #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) dut (
    .Clk_In     (Clk_In),
    .Reset_n_In (Reset_n_In),
    .Enable_In  (Enable_In),
    .Start_In   (Start_In),
    .Signed_In  (Signed_In),
    .Data_A_In  (Data_A_In),
    .Data_B_In  (Data_B_In),
    .Busy_Out   (Busy_Out),
    .Valid_Out  (Valid_Out),
    .A_gt_B_Out (A_gt_B_Out),
    .A_eq_B_Out (A_eq_B_Out),
    .A_lt_B_Out (A_lt_B_Out)
  );

  always #5 Clk_In = ~Clk_In;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // With Enable_In low a flag must not be driven high, whatever its held value.
  task automatic chk_off(input string name, input logic v);
    n_vec++;
    if (v === 1'b1) begin
      n_bad++;
      $display("FAIL %s: got 1, expected z (output disabled)", name);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    Data_A_In = a;
    Data_B_In = b;
    Signed_In = sgn;
    Start_In  = 1'b1;
    @(negedge Clk_In);
    Start_In  = 1'b0;
    Data_A_In = $urandom;
    Data_B_In = $urandom;
    Signed_In = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int k, output logic ok);
    k  = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (Valid_Out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (Busy_Out === 1'b1) k++;
      @(negedge Clk_In);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   k;
    logic ok;
    start_op(v.a, v.b, v.sgn);
    wait_done(k, ok);
    chk({v.name, " done"}, 32'(ok), 32'd1);
    chk({v.name, " k"}, 32'(k), 32'(v.k));
    chk({v.name, " gt"}, 32'(A_gt_B_Out), 32'(v.gt));
    chk({v.name, " eq"}, 32'(A_eq_B_Out), 32'(v.eq));
    chk({v.name, " lt"}, 32'(A_lt_B_Out), 32'(v.lt));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   k;
    logic ok;
    logic saw_valid;

    vecs[0]  = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 4, "eq_unsigned"};
    vecs[1]  = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1, "msb_unsigned"};
    vecs[2]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1, "msb_signed"};
    vecs[3]  = '{32'h12345679, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 4, "lsb_gt"};
    vecs[4]  = '{32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b0, 1'b1, 4, "lsb_lt_b2b"};
    vecs[5]  = '{32'h00000005, 32'h00000009, 1'b0, 1'b0, 1'b0, 1'b1, 4, "small_lt"};
    vecs[6]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1, "neg1_vs_0"};
    vecs[7]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4, "neg2_vs_neg1"};
    vecs[8]  = '{32'h00010000, 32'h00020000, 1'b0, 1'b0, 1'b0, 1'b1, 2, "slice1_lt"};
    vecs[9]  = '{32'h12FF0000, 32'h12010000, 1'b1, 1'b1, 1'b0, 1'b0, 2, "slice1_nosign"};
    vecs[10] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 4, "eq_signed"};
    vecs[11] = '{32'h00000100, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 3, "slice2_gt"};

    Reset_n_In = 1'b0;
    Enable_In  = 1'b1;
    Start_In   = 1'b0;
    Signed_In  = 1'b0;
    Data_A_In  = '0;
    Data_B_In  = '0;
    repeat (3) @(negedge Clk_In);
    chk("rst busy", 32'(Busy_Out), 32'd0);
    chk("rst valid", 32'(Valid_Out), 32'd0);
    chk("rst gt", 32'(A_gt_B_Out), 32'd0);
    chk("rst eq", 32'(A_eq_B_Out), 32'd0);
    chk("rst lt", 32'(A_lt_B_Out), 32'd0);
    Reset_n_In = 1'b1;
    @(negedge Clk_In);

    // Each vector starts in the DONE cycle of the previous one (back-to-back).
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);
    @(negedge Clk_In);
    chk("valid pulse width", 32'(Valid_Out), 32'd0);
    chk("idle after done", 32'(Busy_Out), 32'd0);

    // Start pulses with fresh data on every busy cycle must be ignored.
    start_op(32'h12345678, 32'h12345678, 1'b0);
    k = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (Valid_Out === 1'b1) begin
        Start_In = 1'b0;
        ok = 1'b1;
        break;
      end
      if (Busy_Out === 1'b1) begin
        k++;
        Start_In  = 1'b1;
        Data_A_In = $urandom;
        Data_B_In = $urandom | 32'h1;
        Signed_In = 1'($urandom_range(0, 1));
      end
      @(negedge Clk_In);
    end
    chk("ignore done", 32'(ok), 32'd1);
    chk("ignore k", 32'(k), 32'd4);
    chk("ignore eq", 32'(A_eq_B_Out), 32'd1);
    chk("ignore gt", 32'(A_gt_B_Out), 32'd0);
    chk("ignore lt", 32'(A_lt_B_Out), 32'd0);
    @(negedge Clk_In);
    chk("ignore then idle", 32'(Busy_Out), 32'd0);

    // Reset in the second COMPARE cycle aborts the operation.
    start_op(32'h12345679, 32'h12345678, 1'b0);
    @(negedge Clk_In);
    Reset_n_In = 1'b0;
    #1;
    chk("abort busy", 32'(Busy_Out), 32'd0);
    chk("abort valid", 32'(Valid_Out), 32'd0);
    chk("abort gt", 32'(A_gt_B_Out), 32'd0);
    chk("abort eq", 32'(A_eq_B_Out), 32'd0);
    chk("abort lt", 32'(A_lt_B_Out), 32'd0);
    saw_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk_In);
      if (Valid_Out === 1'b1) saw_valid = 1'b1;
    end
    Reset_n_In = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk_In);
      if (Valid_Out === 1'b1) saw_valid = 1'b1;
    end
    chk("abort no valid", 32'(saw_valid), 32'd0);
    run_vec('{32'h12345679, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 4, "after_abort"});
    @(negedge Clk_In);

    // Disabled outputs: held gt=1 must vanish, new lt=1 must appear only on re-enable.
    Enable_In = 1'b0;
    #1;
    chk_off("dis held gt", A_gt_B_Out);
    @(negedge Clk_In);
    start_op(32'h00000005, 32'h00000009, 1'b0);
    wait_done(k, ok);
    chk("dis valid pulse", 32'(ok), 32'd1);
    chk("dis k", 32'(k), 32'd4);
    chk_off("dis lt", A_lt_B_Out);
    chk_off("dis eq", A_eq_B_Out);
    Enable_In = 1'b1;
    #1;
    chk("en lt", 32'(A_lt_B_Out), 32'd1);
    chk("en gt", 32'(A_gt_B_Out), 32'd0);
    chk("en eq", 32'(A_eq_B_Out), 32'd0);
    repeat (2) @(negedge Clk_In);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
